// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time copier from combinational program ROM into main memory
// Walks ROM from address 0, one READ/WRITE pair per byte, until the ROM flags the last byte.
module rom_loader #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_error,
  output logic        cpu_hold,
  output logic [31:0] byte_count,
  output logic [7:0]  checksum
);

  localparam logic [31:0] MAX_B = 32'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERROR} state_e;

  state_e      state_q, state_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        last_q, last_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  sum_q, sum_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    count_d    = count_q;
    sum_d      = sum_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_READ;
          rom_addr_d = '0;
          count_d    = '0;
          sum_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      S_READ: begin
        wdata_d    = rom_byte;
        last_d     = rom_done;
        mem_addr_d = MEM_BASE + rom_addr_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          count_d = count_q + 32'd1;
          sum_d   = sum_q + wdata_q;
          // The last-byte flag wins over the byte limit when both hit on the same write.
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (count_q + 32'd1 == MAX_B) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 32'd1;
            state_d    = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_address = rom_addr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = (state_q == S_WRITE);
  assign busy        = (state_q == S_READ) || (state_q == S_WRITE);
  assign load_done   = done_q;
  assign load_error  = error_q;
  assign cpu_hold    = ~done_q;
  assign byte_count  = count_q;
  assign checksum    = sum_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader with a stub ROM and stalling memory
module tb_rom_loader;

  localparam logic [31:0] MEM_BASE = 32'hFFFF_FFFE;
  localparam int MAXB = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy, load_done, load_error, cpu_hold;
  logic [31:0] byte_count;
  logic [7:0]  checksum;

  rom_loader #(.MEM_BASE(MEM_BASE), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .load_done(load_done), .load_error(load_error), .cpu_hold(cpu_hold),
    .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [7:0]  sum;
    logic        done;
    logic        err;
    longint      fin;
  } res_t;

  logic [7:0]  rom_img [16];
  int          done_at = -1;
  int          st [16];
  logic [39:0] wq [$];
  res_t        rq [$];
  int          stall_q [$];
  int          stall_cnt = 0;
  longint      cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  assign rom_byte = (rom_address < 32'd16) ? rom_img[rom_address[3:0]] : 8'h00;
  assign rom_done = (done_at >= 0) && (rom_address == 32'(done_at));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_address"}, rom_address, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_load_error"}, load_error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_byte_count"}, byte_count, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // Memory model: stalls each write by a preloaded cycle count; ready is random when idle.
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_we) begin
      if (stall_cnt > 0) begin
        mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_ready = 1'b1;
        stall_cnt = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks accepted writes, stall stability and end-of-load results.
  initial begin
    logic        prev_busy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("stall_mem_we", mem_we, 1);
          chk("stall_mem_addr", mem_addr, prev_addr);
          chk("stall_mem_wdata", mem_wdata, prev_data);
        end
        if (mem_we && mem_ready) begin
          chk("write_expected", wq.size() > 0, 1);
          if (wq.size() > 0) begin
            logic [39:0] e;
            e = wq.pop_front();
            chk("write_addr", mem_addr, e[39:8]);
            chk("write_data", mem_wdata, e[7:0]);
          end
        end
        if (prev_busy && !busy) begin
          chk("result_expected", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            res_t r;
            r = rq.pop_front();
            chk("byte_count", byte_count, r.cnt);
            chk("checksum", checksum, r.sum);
            chk("load_done", load_done, r.done);
            chk("load_error", load_error, r.err);
            chk("cpu_hold", cpu_hold, !r.done);
            chk("finish_cycle", cyc, r.fin);
          end
        end
      end
      prev_stall = rst_n && mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      prev_busy  = busy;
    end
  end

  // Reference: copy stops at the done byte if it lies within the limit, else after MAXB bytes.
  task automatic run_load(input int d_at);
    int n, s;
    logic err;
    logic [7:0] sum;
    res_t r;
    bit ok;
    done_at = d_at;
    if (d_at >= 0 && d_at < MAXB) begin n = d_at + 1; err = 1'b0; end
    else begin n = MAXB; err = 1'b1; end
    sum = 8'h00;
    s = 0;
    for (int i = 0; i < n; i++) begin
      wq.push_back({MEM_BASE + 32'(i), rom_img[i]});
      sum = sum + rom_img[i];
      s = s + st[i];
    end
    stall_cnt = st[0];
    for (int i = 1; i < n; i++) stall_q.push_back(st[i]);
    r.cnt = 32'(n); r.sum = sum; r.done = !err; r.err = err;
    r.fin = cyc + 1 + 2 * n + s;
    rq.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) begin ok = 1'b1; break; end
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) chk("load_finished", busy, 0);
    @(negedge clk);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) st[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_img[i] = 8'h00;
    clear_stalls();
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rom_img[0] = 8'h01; rom_img[1] = 8'h02; rom_img[2] = 8'h03;
    run_load(2);
    st[1] = 3;
    run_load(2);
    clear_stalls();
    for (int i = 0; i < 16; i++) rom_img[i] = 8'hFF;
    run_load(-1);
    rom_img[0] = 8'hA5;
    run_load(0);
    for (int i = 0; i < 16; i++) rom_img[i] = 8'(i + 1);
    run_load(MAXB - 1);
    run_load(MAXB);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) begin
        rom_img[i] = 8'($urandom_range(0, 255));
        st[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0;
      end
      run_load(($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 8));
    end

    // Asynchronous reset while the second write is pending.
    clear_stalls();
    for (int i = 0; i < 16; i++) rom_img[i] = 8'(8'h40 + i);
    done_at = 5;
    for (int i = 0; i < 6; i++) wq.push_back({MEM_BASE + 32'(i), rom_img[i]});
    stall_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mem_we && byte_count == 32'd1) break;
      @(negedge clk);
    end
    chk("reached_second_write", mem_we && byte_count == 32'd1, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    wq.delete();
    stall_q.delete();
    stall_cnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_mem_we", mem_we, 0);
      chk("post_reset_busy", busy, 0);
    end

    rom_img[0] = 8'h01; rom_img[1] = 8'h02; rom_img[2] = 8'h03;
    run_load(2);
    repeat (3) @(negedge clk);
    chk("writes_drained", wq.size(), 0);
    chk("results_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time reader for the combinational program ROM. After a start pulse it walks the ROM address from 0 upward and copies each byte into main memory through a ready/valid write port. It stops after the byte at which the ROM asserts `done`, and holds the CPU in reset until the copy finishes. It sits between the ROM image generated by the toolchain and the memory arbiter, and is the only writer of memory during boot.

## Interface
- `MEM_BASE`, default 32'h0000_0000: memory address that ROM byte 0 is written to.
- `MAX_BYTES`, default 65536: byte limit. If this many bytes are copied without the ROM asserting `done`, the load aborts with an error.
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin or restart a load.
- `rom_address`  out  32  address presented to the ROM.
- `rom_byte`  in  8  ROM data, combinational from `rom_address`.
- `rom_done`  in  1  ROM flag: the current address holds the last byte of the image.
- `mem_addr`  out  32  memory write address.
- `mem_wdata`  out  8  memory write data.
- `mem_we`  out  1  write request (valid).
- `mem_ready`  in  1  memory accepts the write in this cycle.
- `busy`  out  1  a load is in progress.
- `load_done`  out  1  the image was copied successfully; sticky.
- `load_error`  out  1  `MAX_BYTES` was reached without `rom_done`; sticky.
- `cpu_hold`  out  1  keeps the CPU in reset; high until `load_done`.
- `byte_count`  out  32  number of bytes accepted by memory.
- `checksum`  out  8  modulo-256 sum of the bytes accepted by memory.

## Operation
- States:
  - IDLE: no load has run since reset.
  - READ: latch ROM outputs.
  - WRITE: present the latched byte to memory.
  - DONE: load finished successfully.
  - ERROR: load aborted on the byte limit.
- IDLE, DONE, ERROR on `start`=1:
  - clear `byte_count`, `checksum`, `load_done`, `load_error`;
  - set `rom_address`=0;
  - go to READ.
- READ:
  - register `rom_byte` into `mem_wdata` and `rom_done` into an internal last flag;
  - set `mem_addr` = `MEM_BASE` + `rom_address`, 32-bit add with wrap-around;
  - go to WRITE.
- WRITE:
  - drive `mem_we`=1.
  - While `mem_ready`=0, stay in WRITE; `mem_addr` and `mem_wdata` are held stable.
  - On `mem_ready`=1, the write is accepted:
    - `byte_count` += 1;
    - `checksum` += `mem_wdata`, mod 256.
  - Then, in this priority order:
    - last flag set: go to DONE.
    - `byte_count`+1 == `MAX_BYTES`: go to ERROR.
    - otherwise: `rom_address` += 1, go to READ.
- The byte at the `rom_done` address is copied, so `byte_count` = last address + 1.
- DONE: `load_done`=1, `cpu_hold`=0.
- ERROR: `load_error`=1, `cpu_hold` stays 1.
- `start` is ignored in READ and WRITE.
- `busy` is 1 exactly in READ and WRITE.
- `rom_address` holds its value in DONE and ERROR.

## Timing
- Reset values:
  - state IDLE;
  - `rom_address`, `mem_addr`, `byte_count` = 0;
  - `mem_wdata`, `checksum` = 0;
  - `mem_we`, `busy`, `load_done`, `load_error` = 0;
  - `cpu_hold` = 1.
- Reset asserted mid-load takes effect immediately and asynchronously:
  - all outputs go to their reset values;
  - `mem_we` drops without waiting for `mem_ready`;
  - the load does not resume after release; a new `start` is required.
- `start` sampled at edge E0 gives READ after E0 and WRITE (`mem_we`=1) after E1.
- With `mem_ready` held at 1, each byte costs 2 cycles. For an N-byte image, `load_done` rises after edge E0+2N.
- Each cycle of `mem_ready`=0 during WRITE adds exactly one cycle.
- `mem_ready` outside WRITE is ignored.
- `mem_we` is never asserted in READ, so the write port carries a bubble between consecutive writes.
- `rom_done` and `rom_byte` are sampled only at the READ edge.
- `load_done` and `cpu_hold` change in the same edge that enters DONE.

## Test plan
- Stub ROM 01,02,03 with `done` at address 2, `MEM_BASE`=32'h100, `mem_ready`=1, pulse `start`:
  - writes (0x100,01), (0x101,02), (0x102,03) occur on consecutive odd cycles;
  - `byte_count`=3, `checksum`=06;
  - `load_done` rises 6 cycles after `start`, with `cpu_hold` falling on the same edge.
- Same ROM, `mem_ready` held low for 3 cycles on the second write:
  - `mem_we`, `mem_addr`=0x101 and `mem_wdata`=02 stay stable for those cycles;
  - `load_done` arrives 3 cycles later, at cycle 9;
  - `checksum`=06.
- `rom_done` never asserted, `MAX_BYTES`=4, ROM bytes FF,FF,FF,FF:
  - ERROR after the 4th accepted write;
  - `load_error`=1, `byte_count`=4, `checksum`=FC, `cpu_hold`=1, `load_done`=0.
- `done` at address 0 with byte A5:
  - exactly one write, `byte_count`=1, `checksum`=A5;
  - `load_done` 2 cycles after `start`.
- `start` pulsed again during WRITE of byte 1 is ignored, and the load finishes normally. A subsequent `start` in DONE:
  - clears `load_done`, `byte_count`, `checksum` in that cycle;
  - repeats the identical sequence.
- `rst_n` asserted asynchronously mid-WRITE:
  - outputs go to reset values before the next clock edge;
  - after release, state stays IDLE and there is no `mem_we` until `start`.
